// File: rtl/conv_fprop_mul_arb.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ requesters, with an ID tag pipe.
// Optional statistics counters are built only when CONV_FPROP_MUL_ARB_STAT_EN is defined.
module conv_fprop_mul_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [31*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic                  mul_ce,
    output logic [30:0]           mul_din0,
    output logic [31:0]           mul_din1,
    input  logic [57:0]           mul_dout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [57:0]           rsp_data,
    output logic [31:0]           stat_grants,
    output logic [31:0]           stat_stalls
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic            tag_v  [MUL_LAT];
    logic [ID_W-1:0] tag_id [MUL_LAT];
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_nxt;
    logic [ID_W-1:0] gid;
    logic [ID_W-1:0] sel;
    logic            found;
    logic            adv;
    logic            grant_acc;

    assign rsp_valid = tag_v[MUL_LAT-1];
    assign rsp_id    = tag_id[MUL_LAT-1];
    assign rsp_data  = mul_dout;
    assign adv       = !rsp_valid || rsp_ready;
    assign mul_ce    = adv;
    assign grant_acc = found && adv && !reset;

    // Scan ptr, ptr+1, ... wrapping at NUM_REQ; first valid requester wins.
    always_comb begin
        int idx;
        found = 1'b0;
        gid   = ptr;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[ID_W'(idx)]) begin
                found = 1'b1;
                gid   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_acc && (gid == ID_W'(i));
        end
    end

    // With no grant the multiplier still sees ptr's operands; the tag marks them invalid.
    always_comb begin
        sel      = found ? gid : ptr;
        mul_din0 = req_a[30:0];
        mul_din1 = req_b[31:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == ID_W'(i)) begin
                mul_din0 = req_a[i*31 +: 31];
                mul_din1 = req_b[i*32 +: 32];
            end
        end
    end

    assign ptr_nxt = (gid == LAST_ID) ? '0 : gid + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_v[s]  <= 1'b0;
                tag_id[s] <= '0;
            end
        end else begin
            if (adv) begin
                tag_v[0]  <= grant_acc;
                tag_id[0] <= gid;
                for (int s = 1; s < MUL_LAT; s++) begin
                    tag_v[s]  <= tag_v[s-1];
                    tag_id[s] <= tag_id[s-1];
                end
            end
            if (grant_acc) ptr <= ptr_nxt;
        end
    end

`ifdef CONV_FPROP_MUL_ARB_STAT_EN
    logic [31:0] grant_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (grant_acc) grant_cnt <= grant_cnt + 32'd1;
            if (rsp_valid && !rsp_ready) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stat_grants = grant_cnt;
    assign stat_stalls = stall_cnt;
`else
    assign stat_grants = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_conv_fprop_mul_arb.sv
// Randomized and directed bench for conv_fprop_mul_arb against a queue-based reference model.
module tb_conv_fprop_mul_arb;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [31*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic              mul_ce;
    logic [30:0]       mul_din0;
    logic [31:0]       mul_din1;
    logic [57:0]       mul_dout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [57:0]       rsp_data;
    logic [31:0]       stat_grants;
    logic [31:0]       stat_stalls;

    conv_fprop_mul_arb #(.NUM_REQ(N), .ID_W(IDW), .MUL_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_ce(mul_ce), .mul_din0(mul_din0),
        .mul_din1(mul_din1), .mul_dout(mul_dout), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .stat_grants(stat_grants), .stat_stalls(stat_stalls)
    );

    always #5 clk = ~clk;

    function automatic logic [57:0] prod(input logic [30:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed({33'b0, a}) * $signed({{32{b[31]}}, b});
        return p[57:0];
    endfunction

    // Multiplier stand-in: LAT register stages gated by mul_ce.
    logic [57:0] mpipe [LAT];
    always @(posedge clk) begin
        if (mul_ce) begin
            mpipe[0] <= prod(mul_din0, mul_din1);
            for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
        end
    end
    assign mul_dout = mpipe[LAT-1];

    typedef struct {
        int          id;
        logic [57:0] p;
        int          age;
    } ent_t;

    ent_t        q[$];
    int          mptr;
    logic [31:0] eg, es;
    int          nvec, nerr;
    logic [30:0] a_r [N];
    logic [31:0] b_r [N];
    logic [N-1:0] v_r;
    int          last_g;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic rr);
        req_valid = v_r;
        for (int i = 0; i < N; i++) begin
            req_a[i*31 +: 31] = a_r[i];
            req_b[i*32 +: 32] = b_r[i];
        end
        rsp_ready = rr;
    endtask

    // One clock cycle: drive, check against the model, then advance the model past the edge.
    task automatic cycle(input logic rr);
        logic         exp_rv, adv;
        logic [N-1:0] exp_ready;
        int           g;
        @(negedge clk);
        reset = 1'b0;
        drive(rr);
        #1;
        exp_rv = (q.size() > 0) && (q[0].age == LAT);
        adv    = !exp_rv || rr;
        g      = -1;
        if (adv) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (mptr + k) % N;
                if (g < 0 && v_r[i]) g = i;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("mul_ce", 64'(mul_ce), 64'(adv));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (exp_rv) begin
            chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
            chk("rsp_data", 64'(rsp_data), 64'(q[0].p));
        end
`ifdef CONV_FPROP_MUL_ARB_STAT_EN
        chk("stat_grants", 64'(stat_grants), 64'(eg));
        chk("stat_stalls", 64'(stat_stalls), 64'(es));
`else
        chk("stat_grants", 64'(stat_grants), 64'd0);
        chk("stat_stalls", 64'(stat_stalls), 64'd0);
`endif
        if (exp_rv && !rr) es++;
        if (adv) begin
            if (exp_rv) void'(q.pop_front());
            foreach (q[j]) q[j].age++;
        end
        if (g >= 0) begin
            q.push_back('{g, prod(a_r[g], b_r[g]), 1});
            mptr = (g + 1) % N;
            eg++;
        end
        last_g = g;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        q.delete();
        mptr = 0;
        eg = '0;
        es = '0;
        last_g = -1;
    endtask

    // Granted requesters pick fresh operands; ungranted ones keep theirs (handshake rule).
    task automatic refresh_granted();
        if (last_g >= 0) begin
            a_r[last_g] = 31'($urandom);
            b_r[last_g] = $urandom;
        end
    endtask

    task automatic refresh_random();
        for (int i = 0; i < N; i++) begin
            if (v_r[i] && last_g != i) begin
                if ($urandom_range(0, 9) == 0) v_r[i] = 1'b0;
            end else begin
                v_r[i] = 1'($urandom_range(0, 1));
                a_r[i] = 31'($urandom);
                b_r[i] = $urandom;
            end
        end
    endtask

    initial begin
        int fair_ok;
        nvec = 0; nerr = 0; eg = '0; es = '0; mptr = 0; last_g = -1;
        reset = 1'b1; rsp_ready = 1'b1; v_r = '0;
        for (int i = 0; i < N; i++) begin a_r[i] = '0; b_r[i] = '0; end
        drive(1'b1);
        do_reset();

        // Single request from requester 2: 5 * -3.
        v_r = 4'b0100; a_r[2] = 31'd5; b_r[2] = 32'hFFFF_FFFD;
        cycle(1'b1);
        chk("single_grant", 64'(last_g), 64'd2);
        v_r = '0;
        for (int c = 0; c < LAT + 1; c++) cycle(1'b1);

        // All requesting continuously.
        v_r = '1;
        for (int c = 0; c < 10; c++) begin cycle(1'b1); refresh_granted(); end

        // Backpressure for 3 cycles while results are pending.
        for (int c = 0; c < 3; c++) cycle(1'b0);
        for (int c = 0; c < 6; c++) begin cycle(1'b1); refresh_granted(); end
        v_r = '0;
        for (int c = 0; c < LAT + 1; c++) cycle(1'b1);

        // Fairness: req 0 always valid, req 3 joins at cycle 5.
        do_reset();
        v_r = 4'b0001;
        fair_ok = 0;
        for (int c = 0; c < 5 + N + 1; c++) begin
            if (c == 5) v_r[3] = 1'b1;
            cycle(1'b1);
            if (last_g == 3 && c <= 5 + N) begin fair_ok = 1; v_r[3] = 1'b0; end
            refresh_granted();
        end
        chk("fair_grant", 64'(fair_ok), 64'd1);
        v_r = '0;
        for (int c = 0; c < LAT + 1; c++) cycle(1'b1);

        // Reset with two products in flight; next grant goes to lowest valid index.
        v_r = 4'b0110;
        cycle(1'b1); refresh_granted();
        cycle(1'b1); refresh_granted();
        do_reset();
        v_r = 4'b1010;
        cycle(1'b1);
        chk("post_rst_grant", 64'(last_g), 64'd1);
        v_r = '0;
        for (int c = 0; c < LAT + 1; c++) cycle(1'b1);

        // Operand extremes.
        v_r = 4'b0010; a_r[1] = 31'h7FFF_FFFF; b_r[1] = 32'h8000_0000;
        cycle(1'b1);
        v_r = 4'b1000; a_r[3] = 31'h7FFF_FFFF; b_r[3] = 32'h7FFF_FFFF;
        cycle(1'b1);
        v_r = '0;
        for (int c = 0; c < LAT + 1; c++) cycle(1'b1);

        // Random traffic with random backpressure.
        for (int c = 0; c < 500; c++) begin
            refresh_random();
            cycle($urandom_range(0, 3) != 0);
        end
        v_r = '0;
        for (int c = 0; c < LAT + 2; c++) cycle(1'b1);
        chk("drained", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
